// File: rtl/cnn_pkg.sv
// Shared types and helpers for the time-multiplexed CNN array: FSM states,
// index/accumulator widths, saturation and 3x3 template tap constants.
package cnn_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN,
      S_SWAP,
      S_FIN
   } state_t;

   localparam int TAPS   = 9;
   localparam int CENTRE = 4;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int acc_w(input int dw, input int tw);
      return 2 * dw + tw + 4;
   endfunction

   // Clamp to the signed dw-bit range; the caller narrows the result to dw bits.
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/cnn_cell_mac.sv
// Combinational 3x3 cell datapath: sum(A*y) + sum(B*u) + (bias << FRAC)
// evaluated at full accumulator width, no rounding or clamping here.
module cnn_cell_mac
   import cnn_pkg::*;
#(
   parameter int DW   = 9,
   parameter int TW   = 8,
   parameter int FRAC = 4,
   parameter int AW   = acc_w(DW, TW)
) (
   input  logic [TAPS*DW-1:0]   y,
   input  logic [TAPS*DW-1:0]   u,
   input  logic [TAPS*TW-1:0]   a_tmpl,
   input  logic [TAPS*TW-1:0]   b_tmpl,
   input  logic [DW-1:0]        bias,
   output logic signed [AW-1:0] acc
);

   always_comb begin
      logic signed [TW-1:0] ak;
      logic signed [TW-1:0] bk;
      logic signed [DW-1:0] yk;
      logic signed [DW-1:0] uk;
      logic signed [DW-1:0] bias_s;
      bias_s = $signed(bias);
      acc    = AW'(bias_s) <<< FRAC;
      for (int k = 0; k < TAPS; k++) begin
         ak  = $signed(a_tmpl[k*TW +: TW]);
         bk  = $signed(b_tmpl[k*TW +: TW]);
         yk  = $signed(y[k*DW +: DW]);
         uk  = $signed(u[k*DW +: DW]);
         acc = acc + AW'(ak) * AW'(yk) + AW'(bk) * AW'(uk);
      end
   end

endmodule

// File: rtl/cnn_array_seq.sv
// ROWS x COLS CNN array sharing one cell MAC in raster order, ping-pong state
// banks per Euler iteration. Optional early stop on convergence: CNN_CONV_EN.
module cnn_array_seq
   import cnn_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DW   = 9,
   parameter int TW   = 8,
   parameter int FRAC = 4,
   parameter int ITW  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [ITW-1:0]                    iter_num,
   input  logic [TAPS*TW-1:0]                a_tmpl,
   input  logic [TAPS*TW-1:0]                b_tmpl,
   input  logic [DW-1:0]                     bias,
   input  logic                              ld_we,
   input  logic                              ld_sel,
   input  logic [idx_w(ROWS*COLS)-1:0]       ld_addr,
   input  logic [DW-1:0]                     ld_data,
   input  logic [idx_w(ROWS*COLS)-1:0]       rd_addr,
   output logic [DW-1:0]                     rd_data,
   output logic                              busy,
   output logic                              done,
   output logic                              converged
);

   localparam int N  = ROWS * COLS;
   localparam int IW = idx_w(N);
   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);
   localparam int AW = acc_w(DW, TW);

   state_t                state_q, state_d;
   logic                  bank_q;
   logic [ITW-1:0]        rem_q;
   logic [TAPS*TW-1:0]    a_q, b_q;
   logic [DW-1:0]         bias_q;
   logic [IW-1:0]         idx_q;
   logic [RW-1:0]         row_q;
   logic [CW-1:0]         col_q;
   logic signed [AW-1:0]  mac_acc, acc_q;
   logic                  wr_vld_q;
   logic [IW-1:0]         wr_idx_q;
   logic [DW-1:0]         wr_val;
   logic [DW-1:0]         st [2][N];
   logic [DW-1:0]         u_mem [N];
   logic [TAPS*DW-1:0]    y_vec, u_vec;
   logic                  conv_stop;
   logic                  scan_last;

   assign scan_last = (idx_q == IW'(N - 1));
   assign wr_val    = DW'(sat(64'(acc_q >>> FRAC), DW));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = (iter_num == '0) ? S_FIN : S_SCAN;
         S_SCAN: begin
            busy = 1'b1;
            if (scan_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy    = 1'b1;
            state_d = S_SWAP;
         end
         S_SWAP: begin
            busy    = 1'b1;
            state_d = (rem_q == ITW'(1) || conv_stop) ? S_FIN : S_SCAN;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Scan position, iteration bookkeeping and latched run parameters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q <= 1'b0;
         rem_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         bias_q <= '0;
         idx_q  <= '0;
         row_q  <= '0;
         col_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               rem_q  <= iter_num;
               a_q    <= a_tmpl;
               b_q    <= b_tmpl;
               bias_q <= bias;
               idx_q  <= '0;
               row_q  <= '0;
               col_q  <= '0;
            end
            S_SCAN: begin
               idx_q <= idx_q + 1'b1;
               if (col_q == CW'(COLS - 1)) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            S_SWAP: begin
               bank_q <= ~bank_q;
               rem_q  <= rem_q - 1'b1;
               idx_q  <= '0;
               row_q  <= '0;
               col_q  <= '0;
            end
            default: ;
         endcase
      end
   end

   // Zero-padded 3x3 neighbourhood of the current cell from the active bank.
   always_comb begin
      int r;
      int c;
      y_vec = '0;
      u_vec = '0;
      for (int k = 0; k < TAPS; k++) begin
         r = int'(row_q) + k / 3 - 1;
         c = int'(col_q) + k % 3 - 1;
         if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            y_vec[k*DW +: DW] = st[bank_q][IW'(r * COLS + c)];
            u_vec[k*DW +: DW] = u_mem[IW'(r * COLS + c)];
         end
      end
   end

   cnn_cell_mac #(
      .DW   (DW),
      .TW   (TW),
      .FRAC (FRAC),
      .AW   (AW)
   ) u_mac (
      .y      (y_vec),
      .u      (u_vec),
      .a_tmpl (a_q),
      .b_tmpl (b_q),
      .bias   (bias_q),
      .acc    (mac_acc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         wr_vld_q <= 1'b0;
         wr_idx_q <= '0;
      end else begin
         acc_q    <= mac_acc;
         wr_vld_q <= (state_q == S_SCAN);
         wr_idx_q <= idx_q;
      end
   end

   // Pipeline writes go to the shadow bank; host loads only land while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            st[0][i]  <= '0;
            st[1][i]  <= '0;
            u_mem[i]  <= '0;
         end
         rd_data <= '0;
      end else begin
         if (wr_vld_q) st[~bank_q][wr_idx_q] <= wr_val;
         if (ld_we && !busy && int'(ld_addr) < N) begin
            if (ld_sel) st[bank_q][ld_addr] <= ld_data;
            else        u_mem[ld_addr]      <= ld_data;
         end
         rd_data <= st[bank_q][rd_addr];
      end
   end

`ifdef CNN_CONV_EN
   logic chg_q;
   logic conv_q;

   // chg_q tracks whether any cell moved during the current iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chg_q  <= 1'b0;
         conv_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && start) conv_q <= 1'b0;
         if (state_q == S_SWAP && !chg_q) conv_q <= 1'b1;
         if (state_d == S_SCAN && state_q != S_SCAN)
            chg_q <= 1'b0;
         else if (wr_vld_q && wr_val != st[bank_q][wr_idx_q])
            chg_q <= 1'b1;
      end
   end

   assign conv_stop = !chg_q;
   assign converged = conv_q;
`else
   assign conv_stop = 1'b0;
   assign converged = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_array_seq.sv
// Directed bench for cnn_array_seq (4x4, DW=9, TW=8, FRAC=4) with
// hand-computed expected cell states and done latencies.
module tb_cnn_array_seq;

   localparam int N  = 16;
   localparam int IL = N + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  iter_num;
   logic [71:0] a_tmpl;
   logic [71:0] b_tmpl;
   logic [8:0]  bias;
   logic        ld_we;
   logic        ld_sel;
   logic [3:0]  ld_addr;
   logic [8:0]  ld_data;
   logic [3:0]  rd_addr;
   logic [8:0]  rd_data;
   logic        busy;
   logic        done;
   logic        converged;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_st [N];

   always #5 clk = ~clk;

   cnn_array_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .iter_num  (iter_num),
      .a_tmpl    (a_tmpl),
      .b_tmpl    (b_tmpl),
      .bias      (bias),
      .ld_we     (ld_we),
      .ld_sel    (ld_sel),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .converged (converged)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] tmpl(input int centre, input int others);
      logic [71:0] t;
      for (int k = 0; k < 9; k++) t[k*8 +: 8] = 8'((k == 4) ? centre : others);
      return t;
   endfunction

   task automatic load(input bit sel, input int addr, input int val);
      @(negedge clk);
      ld_we   = 1'b1;
      ld_sel  = sel;
      ld_addr = 4'(addr);
      ld_data = 9'(val);
      @(negedge clk);
      ld_we   = 1'b0;
   endtask

   task automatic readback_all(input string tag);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         rd_addr = 4'(i);
         @(negedge clk);
         check($sformatf("%s[%0d]", tag, i), $signed(rd_data), exp_st[i]);
      end
   endtask

   task automatic run(input int iters, input logic [71:0] a, input logic [71:0] b,
                      input int bi, input int exp_lat, input bit poke, input int poke_rd);
      int cyc;
      @(negedge clk);
      iter_num = 8'(iters);
      a_tmpl   = a;
      b_tmpl   = b;
      bias     = 9'(bi);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      check("busy_after_start", int'(busy), int'(iters != 0));
      while (!done && cyc < 3000) begin
         if (poke && cyc == 5) begin
            start    = 1'b1;
            iter_num = 8'd5;
            ld_we    = 1'b1;
            ld_sel   = 1'b0;
            ld_addr  = 4'd0;
            ld_data  = 9'd100;
            rd_addr  = 4'd2;
         end
         if (poke && cyc == 6) begin
            start = 1'b0;
            ld_we = 1'b0;
            check("mid_run_rd", $signed(rd_data), poke_rd);
         end
         @(negedge clk);
         cyc++;
      end
      check("done_latency", cyc, exp_lat);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      int lat;
      int seen;
      rst = 1'b1; start = 1'b0; iter_num = '0; a_tmpl = '0; b_tmpl = '0; bias = '0;
      ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_conv", int'(converged), 0);
      for (int i = 0; i < N; i++) exp_st[i] = 0;
      readback_all("reset_st");

      // Identity feedback: states stay put.
      for (int i = 0; i < N; i++) begin load(1'b1, i, i); exp_st[i] = i; end
`ifdef CNN_CONV_EN
      lat = 1 + IL;
`else
      lat = 1 + 3 * IL;
`endif
      run(3, tmpl(16, 0), tmpl(0, 0), 0, lat, 1'b0, 0);
      readback_all("ident");
`ifdef CNN_CONV_EN
      check("ident_conv", int'(converged), 1);
`else
      check("ident_conv", int'(converged), 0);
`endif

      // Control passthrough of u.
      for (int i = 0; i < N; i++) begin load(1'b0, i, i - 8); exp_st[i] = i - 8; end
      run(1, tmpl(0, 0), tmpl(16, 0), 0, 1 + IL, 1'b0, 0);
      readback_all("pass");

      // Zero padding: count of in-array neighbours.
      for (int i = 0; i < N; i++) begin
         load(1'b0, i, 1);
         exp_st[i] = ((i / 4 == 0 || i / 4 == 3) ? 2 : 3) * ((i % 4 == 0 || i % 4 == 3) ? 2 : 3);
      end
      run(1, tmpl(0, 0), tmpl(16, 16), 0, 1 + IL, 1'b0, 0);
      readback_all("pad");

      // Arithmetic shift floors: 8*-3 = -24 -> -2.
      for (int i = 0; i < N; i++) begin load(1'b0, i, -3); exp_st[i] = -2; end
      run(1, tmpl(0, 0), tmpl(8, 0), 0, 1 + IL, 1'b0, 0);
      readback_all("floor");

      // Bias alone.
      for (int i = 0; i < N; i++) exp_st[i] = -7;
      run(1, tmpl(0, 0), tmpl(0, 0), -7, 1 + IL, 1'b0, 0);
      readback_all("bias");

      // Saturation high and low.
      for (int i = 0; i < N; i++) begin load(1'b1, i, 255); exp_st[i] = 255; end
      run(1, tmpl(127, 0), tmpl(0, 0), 0, 1 + IL, 1'b0, 0);
      readback_all("sat_hi");
      for (int i = 0; i < N; i++) begin load(1'b1, i, -256); exp_st[i] = -256; end
      run(1, tmpl(127, 0), tmpl(0, 0), 0, 1 + IL, 1'b0, 0);
      readback_all("sat_lo");

      // iter_num = 0: immediate done, nothing computed.
      run(0, tmpl(0, 0), tmpl(0, 0), 5, 1, 1'b0, 0);
      readback_all("iter0");

      // start/ld_we while busy are ignored; mid-run read sees the old bank.
      for (int i = 0; i < N; i++) exp_st[i] = 3;
      run(1, tmpl(0, 0), tmpl(0, 0), 3, 1 + IL, 1'b1, -256);
      readback_all("busy_ign");
      for (int i = 0; i < N; i++) exp_st[i] = -3;
      run(1, tmpl(0, 0), tmpl(16, 0), 0, 1 + IL, 1'b0, 0);
      readback_all("u_kept");

      // Reset during SCAN of iteration 2 (states change every iteration).
      for (int i = 0; i < N; i++) load(1'b1, i, i);
      @(negedge clk);
      iter_num = 8'd3; a_tmpl = tmpl(16, 0); b_tmpl = tmpl(0, 0); bias = 9'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (23) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      check("rst_no_done", seen, 0);
      check("rst_conv", int'(converged), 0);
      for (int i = 0; i < N; i++) exp_st[i] = 0;
      readback_all("rst_st");

      // Convergence run: identity for up to 10 iterations.
      for (int i = 0; i < N; i++) begin load(1'b1, i, i); exp_st[i] = i; end
`ifdef CNN_CONV_EN
      run(10, tmpl(16, 0), tmpl(0, 0), 0, 1 + IL, 1'b0, 0);
      check("conv_flag", int'(converged), 1);
`else
      run(10, tmpl(16, 0), tmpl(0, 0), 0, 1 + 10 * IL, 1'b0, 0);
      check("conv_flag", int'(converged), 0);
`endif
      readback_all("conv_st");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
